// File: rtl/apb_regfile_bridge.sv
// APB3 slave front-end for the 4-register file: one rf strobe per completed transfer, WAIT_CYCLES+1 cycles after setup.
// Backpressure via pready wait states; address errors complete with pslverr and never touch the register file.
module apb_regfile_bridge #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              rf_wr_en,
    output logic              rf_rd_en,
    output logic [9:0]        rf_addr,
    output logic [31:0]       rf_wdata,
    input  logic [31:0]       rf_rdata
);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("apb_regfile_bridge: WAIT_CYCLES must be in 0..15");
        end
        if (ADDR_W < 10) begin : g_bad_addr
            $error("apb_regfile_bridge: ADDR_W must be >= 10");
        end
    endgenerate

    localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [9:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_dir;
    logic        r_err;

    logic        w_hi_err;
    logic        w_addr_err;
    logic        w_setup;
    logic        w_done;
    logic        w_rd_ok;

    // Any set bit above the 10-bit register window is out of range.
    generate
        if (ADDR_W > 10) begin : g_hi
            assign w_hi_err = |paddr[ADDR_W-1:10];
        end else begin : g_no_hi
            assign w_hi_err = 1'b0;
        end
    endgenerate

    assign w_addr_err = (paddr[1:0] != 2'b00) | w_hi_err;
    assign w_setup    = psel & ~penable;
    assign w_done     = (r_state == S_ACCESS) & psel & penable & (r_cnt == 4'd0);
    assign w_rd_ok    = w_done & ~r_dir & ~r_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 10'd0;
            r_wdata <= 32'd0;
            r_dir   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_setup) begin
                        r_addr  <= paddr[9:0];
                        r_wdata <= pwdata;
                        r_dir   <= pwrite;
                        r_err   <= w_addr_err;
                        r_cnt   <= LP_WAIT;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Dropping psel abandons the transfer without any strobe.
                    if (!psel) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else if (penable) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pready   = w_done;
    assign pslverr  = w_done & r_err;
    assign rf_wr_en = w_done & r_dir & ~r_err;
    assign rf_rd_en = w_rd_ok;
    assign prdata   = w_rd_ok ? rf_rdata : 32'd0;
    assign rf_addr  = (r_state == S_ACCESS) ? r_addr  : 10'd0;
    assign rf_wdata = (r_state == S_ACCESS) ? r_wdata : 32'd0;

endmodule

// File: tb/tb_apb_regfile_bridge.sv
// Bench for apb_regfile_bridge: three instances (WAIT_CYCLES 0/3/2), each with a small register file behind it,
// checked every cycle against a transfer-level model of the APB bridge and the register contents.
module tb_apb_regfile_bridge;

    logic        clk;
    logic        rst;
    logic        psel     [3];
    logic        penable  [3];
    logic        pwrite   [3];
    logic [11:0] paddr    [3];
    logic [31:0] pwdata   [3];
    logic [31:0] prdata   [3];
    logic        pready   [3];
    logic        pslverr  [3];
    logic        rf_wr_en [3];
    logic        rf_rd_en [3];
    logic [9:0]  rf_addr  [3];
    logic [31:0] rf_wdata [3];
    logic [31:0] rf_rdata [3];

    for (genvar k = 0; k < 3; k++) begin : g_dut
        localparam int WC = (k == 0) ? 0 : ((k == 1) ? 3 : 2);
        apb_regfile_bridge #(.ADDR_W(12), .WAIT_CYCLES(WC)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .psel     (psel[k]),
            .penable  (penable[k]),
            .pwrite   (pwrite[k]),
            .paddr    (paddr[k]),
            .pwdata   (pwdata[k]),
            .prdata   (prdata[k]),
            .pready   (pready[k]),
            .pslverr  (pslverr[k]),
            .rf_wr_en (rf_wr_en[k]),
            .rf_rd_en (rf_rd_en[k]),
            .rf_addr  (rf_addr[k]),
            .rf_wdata (rf_wdata[k]),
            .rf_rdata (rf_rdata[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file environment: DATA0 @0x0 (SR_DATA0 @0x4 mirrors it), DATA1 @0x8 (SR_DATA1 @0xC mirrors it).
    logic [31:0] rf_d0 [3];
    logic [31:0] rf_d1 [3];
    int          wr_pulses [3];
    int          rd_pulses [3];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rf_wr_en[k]) wr_pulses[k] <= wr_pulses[k] + 1;
            if (rf_rd_en[k]) rd_pulses[k] <= rd_pulses[k] + 1;
            if (rst) begin
                rf_d0[k] <= 32'h0000_0000;
                rf_d1[k] <= 32'hFFFF_FFFF;
            end else if (rf_wr_en[k]) begin
                if (rf_addr[k] == 10'h000) rf_d0[k] <= rf_wdata[k];
                else if (rf_addr[k] == 10'h008) rf_d1[k] <= rf_wdata[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rf_rdata[k] = 32'd0;
            case (rf_addr[k])
                10'h000, 10'h004: rf_rdata[k] = rf_d0[k];
                10'h008, 10'h00C: rf_rdata[k] = rf_d1[k];
                default:          rf_rdata[k] = 32'd0;
            endcase
        end
    end

    // Transfer-level model state and per-cycle expectations.
    logic [31:0] m_d0 [3];
    logic [31:0] m_d1 [3];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cur   = 0;
    bit          chk_on = 1'b0;
    logic        e_pready, e_pslverr, e_wr, e_rd;
    logic [31:0] e_prdata, e_wdata;
    logic [9:0]  e_addr;

    function automatic int wcs(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 2);
    endfunction

    function automatic logic [31:0] mread(input int k, input logic [11:0] a);
        case (a)
            12'h000, 12'h004: return m_d0[k];
            12'h008, 12'h00C: return m_d1[k];
            default:          return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_d0[k] = 32'h0000_0000;
            m_d1[k] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (inst %0d, t=%0t): got %h, expected %h", nm, cur, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("pready",   32'(pready[cur]),   32'(e_pready));
            chk("pslverr",  32'(pslverr[cur]),  32'(e_pslverr));
            chk("rf_wr_en", 32'(rf_wr_en[cur]), 32'(e_wr));
            chk("rf_rd_en", 32'(rf_rd_en[cur]), 32'(e_rd));
            chk("prdata",   prdata[cur],        e_prdata);
            chk("rf_addr",  32'(rf_addr[cur]),  32'(e_addr));
            chk("rf_wdata", rf_wdata[cur],      e_wdata);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_quiet();
        e_pready = 1'b0; e_pslverr = 1'b0; e_wr = 1'b0; e_rd = 1'b0;
        e_prdata = 32'd0; e_addr = 10'd0; e_wdata = 32'd0;
    endtask

    task automatic idle(input int k, input int n);
        cur = k;
        psel[k] = 1'b0;
        penable[k] = 1'b0;
        exp_quiet();
        repeat (n) step();
    endtask

    // One APB transfer; abort_at >= 0 drops psel in that access cycle, rst_at >= 0 pulses reset there instead.
    task automatic xfer(input int k, input bit wr, input logic [11:0] a, input logic [31:0] d,
                        input int abort_at, input int rst_at, output logic [31:0] rd);
        int wc;
        bit err;
        wc  = wcs(k);
        err = (a[1:0] != 2'b00) || (a[11:10] != 2'b00);
        rd  = 32'd0;
        cur = k;
        psel[k] = 1'b1; penable[k] = 1'b0; pwrite[k] = wr; paddr[k] = a; pwdata[k] = d;
        exp_quiet();
        step();
        for (int i = 0; i <= wc; i++) begin
            penable[k] = 1'b1;
            if (i > 0) begin
                paddr[k]  = 12'($urandom);
                pwdata[k] = $urandom;
                pwrite[k] = !wr;
            end
            exp_quiet();
            e_addr  = a[9:0];
            e_wdata = d;
            if (i == abort_at) begin
                psel[k] = 1'b0;
                penable[k] = 1'b0;
                step();
                return;
            end
            if (i == rst_at) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                psel[k] = 1'b0;
                penable[k] = 1'b0;
                model_reset();
                return;
            end
            if (i == wc) begin
                e_pready  = 1'b1;
                e_pslverr = err;
                e_wr      = wr && !err;
                e_rd      = !wr && !err;
                e_prdata  = (!wr && !err) ? mread(k, a) : 32'd0;
                rd        = e_prdata;
            end
            step();
            if (i == wc && wr && !err) begin
                if (a == 12'h000) m_d0[k] = d;
                else if (a == 12'h008) m_d1[k] = d;
            end
        end
    endtask

    initial begin
        logic [31:0] rd;
        int w0, r0;
        for (int k = 0; k < 3; k++) begin
            psel[k] = 1'b0; penable[k] = 1'b0; pwrite[k] = 1'b0;
            paddr[k] = 12'd0; pwdata[k] = 32'd0;
            wr_pulses[k] = 0; rd_pulses[k] = 0;
        end
        model_reset();
        exp_quiet();
        rst = 1'b1;
        step();
        chk_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cur = k;
            step();
        end
        rst = 1'b0;
        idle(0, 2);

        // Reads after reset, no wait states, back-to-back.
        r0 = rd_pulses[0];
        xfer(0, 1'b0, 12'h000, 32'h0, -1, -1, rd);
        chk("rd_0x0_lit", rd, 32'h0000_0000);
        xfer(0, 1'b0, 12'h008, 32'h0, -1, -1, rd);
        chk("rd_0x8_lit", rd, 32'hFFFF_FFFF);
        idle(0, 1);
        chk("rd_pulse_cnt", 32'(rd_pulses[0] - r0), 32'd2);

        // Write DATA0 then read through SR_DATA0.
        w0 = wr_pulses[0];
        xfer(0, 1'b1, 12'h000, 32'hA5A5_1234, -1, -1, rd);
        xfer(0, 1'b0, 12'h004, 32'h0, -1, -1, rd);
        chk("rd_0x4_lit", rd, 32'hA5A5_1234);
        idle(0, 1);
        chk("wr_pulse_cnt", 32'(wr_pulses[0] - w0), 32'd1);
        chk("data0_lit", rf_d0[0], 32'hA5A5_1234);

        // Three wait states with bus noise during the wait.
        idle(1, 1);
        xfer(1, 1'b1, 12'h008, 32'hDEAD_BEEF, -1, -1, rd);
        xfer(1, 1'b0, 12'h008, 32'h0, -1, -1, rd);
        chk("ws3_rd_lit", rd, 32'hDEAD_BEEF);
        idle(1, 1);
        chk("ws3_data1_lit", rf_d1[1], 32'hDEAD_BEEF);

        // Address errors: unaligned, out of range (write and read).
        idle(0, 1);
        w0 = wr_pulses[0];
        r0 = rd_pulses[0];
        xfer(0, 1'b1, 12'h002, 32'h1111_1111, -1, -1, rd);
        xfer(0, 1'b1, 12'h400, 32'h2222_2222, -1, -1, rd);
        xfer(0, 1'b0, 12'h400, 32'h0, -1, -1, rd);
        chk("err_rd_lit", rd, 32'h0);
        idle(0, 1);
        chk("err_strobes", 32'(wr_pulses[0] - w0 + rd_pulses[0] - r0), 32'd0);
        chk("err_data0_lit", rf_d0[0], 32'hA5A5_1234);
        chk("err_data1_lit", rf_d1[0], 32'hFFFF_FFFF);

        // Abort mid-wait, then back-to-back write and read.
        idle(2, 1);
        w0 = wr_pulses[2];
        xfer(2, 1'b1, 12'h000, 32'h5555_5555, 1, -1, rd);
        xfer(2, 1'b1, 12'h008, 32'hCAFE_F00D, -1, -1, rd);
        xfer(2, 1'b0, 12'h008, 32'h0, -1, -1, rd);
        chk("abort_rd8_lit", rd, 32'hCAFE_F00D);
        xfer(2, 1'b0, 12'h000, 32'h0, -1, -1, rd);
        chk("abort_rd0_lit", rd, 32'h0000_0000);
        idle(2, 1);
        chk("abort_wr_cnt", 32'(wr_pulses[2] - w0), 32'd1);

        // Reset during the access phase of a write.
        idle(1, 1);
        w0 = wr_pulses[1];
        xfer(1, 1'b1, 12'h000, 32'h1234_5678, -1, 1, rd);
        idle(1, 2);
        chk("rst_wr_cnt", 32'(wr_pulses[1] - w0), 32'd0);
        xfer(1, 1'b0, 12'h000, 32'h0, -1, -1, rd);
        chk("rst_rd0_lit", rd, 32'h0000_0000);
        idle(1, 2);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
